// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its datapath.
package proc_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 9;

  // Opcodes live in the top three bits of an IIIXXXYYY word.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] MVI_OP = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [DEF_DATA_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [3:0] {
    IDLE,
    F_ADDR,
    F_CAPT,
    I_ADDR,
    I_CAPT,
    ISSUE,
    IMM,
    WAIT,
    HALT
  } fetch_state_t;

  function automatic logic opcode_is_mvi(input logic [DEF_DATA_W-1:0] word);
    return word[DEF_DATA_W-1 -: 3] == MVI_OP;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Handshake and ROM bus between the fetch sequencer (master) and the control FSM / program ROM (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = proc_pkg::DEF_ADDR_W,
  parameter int DATA_W = proc_pkg::DEF_DATA_W
);
  logic              start;
  logic              done;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  modport master (
    input  start, done, rom_data,
    output rom_addr, din, run, pc, busy, halted
  );

  modport slave (
    output start, done, rom_data,
    input  rom_addr, din, run, pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: wrapping ADDR_W-bit register with increment enable, cleared by reset.
module fetch_pc_counter #(
  parameter int ADDR_W = proc_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches instruction (and mvi immediate) words from a 1-cycle-latency ROM, issues them with a
// one-cycle run pulse, then holds din until the control FSM returns done.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic                clk,
  input logic                resetn,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state;
  logic [DATA_W-1:0] ir_buf;
  logic [DATA_W-1:0] imm_buf;
  logic              is_mvi;
  logic [DATA_W-1:0] din_q;
  logic              run_q;
  logic              busy_q;
  logic              halted_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_inc;
  logic              hit_halt;
  logic              rom_is_mvi;

  assign hit_halt   = (bus.rom_data == HALT_WORD);
  assign rom_is_mvi = (bus.rom_data[DATA_W-1 -: 3] == MVI_OP);

  // The immediate slot is never halt-checked, so I_CAPT always advances.
  assign pc_inc = ((state == F_CAPT) && !hit_halt) || (state == I_CAPT);

  fetch_pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .resetn (resetn),
    .inc    (pc_inc),
    .count  (pc_q)
  );

  assign bus.pc       = pc_q;
  assign bus.rom_addr = pc_q;
  assign bus.din      = din_q;
  assign bus.run      = run_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ir_buf   <= '0;
      imm_buf  <= '0;
      is_mvi   <= 1'b0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= F_ADDR;
            busy_q <= 1'b1;
          end
        end
        F_ADDR: state <= F_CAPT;
        F_CAPT: begin
          if (hit_halt) begin
            state    <= HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            din_q    <= '0;
          end else begin
            ir_buf <= bus.rom_data;
            is_mvi <= rom_is_mvi;
            if (rom_is_mvi) begin
              state <= I_ADDR;
            end else begin
              // Issue straight from the ROM word; ir_buf is only written this edge.
              state <= ISSUE;
              run_q <= 1'b1;
              din_q <= bus.rom_data;
            end
          end
        end
        I_ADDR: state <= I_CAPT;
        I_CAPT: begin
          imm_buf <= bus.rom_data;
          state   <= ISSUE;
          run_q   <= 1'b1;
          din_q   <= ir_buf;
        end
        ISSUE: begin
          if (is_mvi) begin
            state <= IMM;
            din_q <= imm_buf;
          end else begin
            state <= WAIT;
          end
        end
        IMM:     state <= bus.done ? F_ADDR : WAIT;
        WAIT:    if (bus.done) state <= F_ADDR;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model plus directed and random programs.
module tb_instr_fetch_unit;
  import proc_pkg::*;

  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [8:0] rom [32];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks the program as a sequence of issue events with fixed latencies.
  bit         started, outstanding;
  int         start_c, run_c, next_run, imm_c, halt_c, mpc;
  logic [8:0] exp_din, cur_instr, cur_imm;
  bit         cur_mvi;

  task automatic model_reset();
    started = 0; outstanding = 0;
    start_c = NEVER; run_c = NEVER; next_run = NEVER; imm_c = NEVER; halt_c = NEVER;
    mpc = 0; exp_din = '0; cur_instr = '0; cur_imm = '0; cur_mvi = 0;
  endtask

  task automatic schedule(input int t);
    logic [8:0] w;
    w = rom[mpc];
    if (w == HALT_WORD) begin
      halt_c = t + 3;
    end else begin
      cur_instr = w;
      cur_mvi   = (w[8:6] == MVI_OP);
      mpc       = (mpc + 1) % 32;
      if (cur_mvi) begin
        cur_imm  = rom[mpc];
        mpc      = (mpc + 1) % 32;
        next_run = t + 5;
      end else begin
        next_run = t + 3;
      end
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!resetn) begin
      model_reset();
      chk("rst_run", 32'(bus.run), 0);
      chk("rst_din", 32'(bus.din), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    end else begin
      if (cyc == next_run) begin
        exp_din = cur_instr; outstanding = 1; run_c = cyc;
        if (cur_mvi) imm_c = cyc + 1;
      end
      if (cyc == imm_c) exp_din = cur_imm;
      if (cyc >= halt_c) exp_din = '0;
      chk("m_run", 32'(bus.run), 32'(cyc == next_run));
      chk("m_din", 32'(bus.din), 32'(exp_din));
      chk("m_halted", 32'(bus.halted), 32'(cyc >= halt_c));
      chk("m_busy", 32'(bus.busy), 32'(started && cyc > start_c && cyc < halt_c));
      if (cyc >= halt_c) begin
        chk("m_halt_pc", 32'(bus.pc), 32'(mpc));
        chk("m_halt_rom_addr", 32'(bus.rom_addr), 32'(mpc));
      end
      if (!started && bus.start) begin
        started = 1; start_c = cyc;
        schedule(cyc);
      end else if (outstanding && cyc > run_c && bus.done) begin
        outstanding = 0;
        schedule(cyc);
      end
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge; rel counts cycles from start.
  int rel = 0;
  int done_mode = 0;  // 0 manual, 1 random, 2 held high
  bit tog_start = 0;

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    if (done_mode == 1) bus.done = ($urandom % 3 == 0);
    if (done_mode == 2) bus.done = 1'b1;
    if (tog_start) bus.start = $urandom % 2;
  endtask

  task automatic go(input int k);
    while (rel < k) step();
  endtask

  task automatic begin_reset();
    resetn = 1'b0; bus.start = 1'b0; bus.done = 1'b0;
    done_mode = 0; tog_start = 0;
    step();
    for (int i = 0; i < 32; i++) rom[i] = 9'h000;
  endtask

  task automatic launch();
    step();
    resetn = 1'b1;
    bus.start = 1'b1;
    rel = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.done = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 9'h000;

    // Single mv, then reset during WAIT and idle with start low.
    begin_reset();
    rom[0] = 9'b000_001_010; rom[1] = HALT_WORD;
    launch();
    go(2); chk("mv_no_early_run", 32'(bus.run), 0);
    go(3); chk("mv_run", 32'(bus.run), 1); chk("mv_din", 32'(bus.din), 9'h00A);
    go(5); chk("mv_wait_hold", 32'(bus.din), 9'h00A);
    resetn = 1'b0;
    #1;
    chk("midwait_rst_busy", 32'(bus.busy), 0);
    chk("midwait_rst_din", 32'(bus.din), 0);
    step(); step();
    resetn = 1'b1; bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_run", 32'(bus.run), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_rom_addr", 32'(bus.rom_addr), 0);
    end

    // Single mv with done at cycle 6.
    begin_reset();
    rom[0] = 9'b000_001_010; rom[1] = HALT_WORD;
    launch();
    go(3); chk("mv2_run", 32'(bus.run), 1);
    go(6); bus.done = 1'b1;
    go(7); bus.done = 1'b0; chk("mv2_busy", 32'(bus.busy), 1);
    go(9);
    chk("mv2_halted", 32'(bus.halted), 1);
    chk("mv2_pc", 32'(bus.pc), 1);
    chk("mv2_busy_halt", 32'(bus.busy), 0);

    // mvi with immediate.
    begin_reset();
    rom[0] = 9'b001_011_000; rom[1] = 9'h05A; rom[2] = HALT_WORD;
    launch();
    go(4); chk("mvi_no_run4", 32'(bus.run), 0);
    go(5); chk("mvi_run", 32'(bus.run), 1); chk("mvi_din", 32'(bus.din), 9'h058);
    go(6); chk("mvi_imm", 32'(bus.din), 9'h05A); chk("mvi_run6", 32'(bus.run), 0);
    bus.done = 1'b1;
    go(7); bus.done = 1'b0;
    go(9); chk("mvi_halted", 32'(bus.halted), 1); chk("mvi_pc", 32'(bus.pc), 2);

    // done during ISSUE is ignored; long done delay holds din.
    begin_reset();
    rom[0] = 9'h0CB; rom[1] = 9'h08A; rom[2] = HALT_WORD;
    launch();
    go(3); bus.done = 1'b1;
    go(4); bus.done = 1'b0;
    go(6); chk("issue_done_ignored", 32'(bus.run), 0);
    go(24); chk("delay_din_hold", 32'(bus.din), 9'h0CB); bus.done = 1'b1;
    go(25); bus.done = 1'b0;
    go(27); chk("delay_next_run", 32'(bus.run), 1); chk("delay_next_din", 32'(bus.din), 9'h08A);
    go(28); bus.done = 1'b1;
    go(29); bus.done = 1'b0;
    go(31); chk("delay_halted", 32'(bus.halted), 1); chk("delay_pc", 32'(bus.pc), 2);

    // Wrap-around: mvi at 31 takes its immediate from address 0.
    begin_reset();
    rom[0] = 9'h123;
    for (int i = 1; i < 31; i++) rom[i] = 9'h08A;
    rom[31] = 9'h040;
    launch();
    done_mode = 2;
    begin
      int budget;
      budget = 0;
      while (!(bus.run && bus.din == 9'h040) && budget < 400) begin
        step();
        budget++;
      end
      chk("wrap_mvi_seen", 32'(budget < 400), 1);
    end
    step();
    chk("wrap_imm", 32'(bus.din), 9'h123);
    chk("wrap_pc", 32'(bus.pc), 1);

    // Halt as first word; start/done activity afterwards changes nothing.
    begin_reset();
    rom[0] = HALT_WORD;
    launch();
    go(3); chk("halt_first", 32'(bus.halted), 1); chk("halt_pc", 32'(bus.pc), 0);
    done_mode = 1; tog_start = 1;
    go(40); chk("halt_sticky", 32'(bus.halted), 1);
    begin_reset();
    step();
    chk("halt_cleared", 32'(bus.halted), 0);

    // Random programs with random done timing and start toggling.
    for (int it = 0; it < 20; it++) begin
      int h;
      begin_reset();
      for (int i = 0; i < 32; i++) begin
        logic [8:0] w;
        w = 9'($urandom);
        if ($urandom % 3 == 0) w[8:6] = MVI_OP;
        if (w == HALT_WORD) w = 9'h000;
        rom[i] = w;
      end
      h = $urandom_range(3, 31);
      rom[h] = HALT_WORD;
      if (it % 2 == 0) begin
        rom[h - 2] = 9'h049;
        rom[h - 1] = HALT_WORD;
      end
      launch();
      done_mode = 1; tog_start = 1;
      go(250);
    end

    begin_reset();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
